// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage in front of the opcode decoder.
// Owns the PC, issues req/ack reads to instruction memory, holds the fetched
// word until decode accepts it, and applies branch/jump redirects.
// Optional build macro: FETCH_PERF_CNT_EN adds fetchCount/killCount counters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   imemReq/imemAddr          read request and its word address (held until ack)
//   imemAck/imemData          read completion and returned word
//   instr/opcode/pcOut/pcPlus1/instrValid   held instruction to decode
//   instrReady                decode accepts the held instruction
//   redirect/redirectPc       single-cycle redirect pulse and target PC
//   fetchCount/killCount      performance counters (FETCH_PERF_CNT_EN only)
module instr_fetch_unit #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imemReq,
    output logic [ADDR_W-1:0]  imemAddr,
    input  logic               imemAck,
    input  logic [INSTR_W-1:0] imemData,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  pcOut,
    output logic [ADDR_W-1:0]  pcPlus1,
    output logic               instrValid,
    input  logic               instrReady,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        fetchCount,
    output logic [15:0]        killCount,
`endif
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirectPc
);

    localparam int unsigned OPC_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                req_q, req_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic [ADDR_W-1:0]   pc_plus1_q, pc_plus1_d;
    logic                valid_q, valid_d;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0]         fetch_cnt_q;
    logic [15:0]         kill_cnt_q;
    logic                accept_c;
    logic                kill_c;
`endif

    // Next-state, PC and held-instruction logic; redirect outranks everything but reset
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_out_d   = pc_out_q;
        pc_plus1_d = pc_plus1_q;
        valid_d    = valid_q;
`ifdef FETCH_PERF_CNT_EN
        accept_c   = 1'b0;
        kill_c     = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (redirect) pc_d = redirectPc;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect) begin
                    pc_d    = redirectPc;
                    valid_d = 1'b0;
                    // An un-acked request cannot be withdrawn, so wait it out in DRAIN
                    state_d = imemAck ? ST_FETCH : ST_DRAIN;
`ifdef FETCH_PERF_CNT_EN
                    kill_c  = 1'b1;
`endif
                end else if (imemAck) begin
                    instr_d    = imemData;
                    pc_out_d   = pc_q;
                    pc_plus1_d = pc_q + ADDR_W'(1);
                    valid_d    = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d    = redirectPc;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
`ifdef FETCH_PERF_CNT_EN
                    kill_c  = 1'b1;
`endif
                end else if (instrReady) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
`ifdef FETCH_PERF_CNT_EN
                    accept_c = 1'b1;
`endif
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    pc_d    = redirectPc;
                    valid_d = 1'b0;
                end
                // Stale data is dropped; refetch from the (possibly updated) pc
                if (imemAck) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase

        // Fetch address only follows pc when a new request starts; DRAIN keeps the old one
        addr_d = (state_d == ST_FETCH) ? pc_d : addr_q;
        req_d  = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            req_q      <= 1'b0;
            instr_q    <= INSTR_W'(0);
            pc_out_q   <= RESET_PC;
            pc_plus1_q <= RESET_PC + ADDR_W'(1);
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            pc_out_q   <= pc_out_d;
            pc_plus1_q <= pc_plus1_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Accepted-instruction counter wraps; kill counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'd0;
            kill_cnt_q  <= 16'd0;
        end else begin
            if (accept_c) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (kill_c && (kill_cnt_q != 16'hFFFF)) kill_cnt_q <= kill_cnt_q + 16'd1;
        end
    end

    assign fetchCount = fetch_cnt_q;
    assign killCount  = kill_cnt_q;
`endif

    assign imemReq    = req_q;
    assign imemAddr   = addr_q;
    assign instr      = instr_q;
    assign opcode     = instr_q[INSTR_W-1 -: OPC_W];
    assign pcOut      = pc_out_q;
    assign pcPlus1    = pc_plus1_q;
    assign instrValid = valid_q;

endmodule
